corebootstrap_ahb_writer: RTL
=============================

Name: corebootstrap_ahb_writer

Overview:
Downstream stage of the SPI reader. It accepts 32-bit bootcode words on the rd_data/rd_data_avail strobe interface and writes them as single-word AHB-Lite transfers to consecutive processor-memory addresses. When the last word is written, and the checksum has passed if enabled, it releases the processor reset. It is the only AHB master in the bootstrap core.

Parameters:
DEST_ADDR, 32'h8000_0000, byte address of the first word written; must be word-aligned.
DATA_WORD_CNT, 100, expected word count; must match the SPI reader's setting.
CKSUM_EN, 0, when 1, release waits for cksum_done and is blocked by CKSUM_ERR.

Ports:
HCLK  in  1  system clock; all logic on rising edge.
HRESET  in  1  synchronous, active-high reset.
rd_data  in  32  word from the SPI reader.
rd_data_avail  in  1  one-cycle strobe: rd_data is valid this cycle.
rd_all_done  in  1  level: the reader has produced every word.
cksum_done  in  1  level: checksum compare complete.
CKSUM_ERR  in  1  level: checksum mismatch.
SW_DEBUG_MODE  in  1  bypass the copy; release the CPU immediately.
HADDR  out  32  AHB address.
HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
HWRITE  out  1  constant 1.
HSIZE  out  3  constant 3'b010 (word).
HBURST  out  3  constant 3'b000 (SINGLE).
HWDATA  out  32  write data, valid during the data phase.
HREADY  in  1  slave ready.
HRESP  in  1  slave error response.
CPU_RESETN  out  1  processor reset, active-low.
wr_all_done  out  1  copy finished successfully (sticky).
WR_ERR  out  1  sticky: AHB error response, count mismatch, or checksum failure.
OVFL_ERR  out  1  sticky: a word arrived with the buffer full.

Behaviour:
- Reset values:
  - HTRANS=00; HADDR=DEST_ADDR; HWDATA=0.
  - CPU_RESETN=0; wr_all_done=0; WR_ERR=0; OVFL_ERR=0.
  - Buffer empty; word counter=0; done latch=0.
- Input buffer:
  - 2-entry FIFO. A push happens on every rd_data_avail cycle. The reader has no backpressure.
  - A push while full drops the word and sets OVFL_ERR. The FIFO is not modified.
  - A push and a pop in the same cycle are both legal.
- rd_all_done is latched into done_seen on its first high cycle.
  - If it arrives in the same cycle as rd_data_avail, the word is still accepted and processed first.
- FSM states:
  - IDLE:
    - SW_DEBUG_MODE=1 -> RELEASE. Takes priority over everything else.
    - FIFO not empty -> ADDR.
    - done_seen and FIFO empty -> CHECK.
  - ADDR:
    - Drive HTRANS=NONSEQ and HADDR=current address.
    - When HREADY=1: pop the FIFO head into HWDATA, go to DATA, and drive HTRANS=IDLE from the next cycle.
    - While HREADY=0: hold HTRANS and HADDR stable.
  - DATA:
    - Hold HWDATA until HREADY=1.
    - HREADY=1 and HRESP=0: address += 4 (mod 2^32), counter += 1, -> IDLE.
    - HRESP=1, first cycle: -> ERROR. HTRANS is already IDLE, which satisfies the two-cycle error response.
  - CHECK:
    - counter != DATA_WORD_CNT -> ERROR.
    - CKSUM_EN=0 -> RELEASE.
    - CKSUM_EN=1: wait for cksum_done; CKSUM_ERR=1 -> ERROR, else -> RELEASE.
  - RELEASE: CPU_RESETN=1 and wr_all_done=1 registered on entry. Terminal until HRESET.
  - ERROR: WR_ERR=1 and CPU_RESETN held 0. Terminal until HRESET. Words still arriving are discarded.
- Latency:
  - rd_data_avail into an empty FIFO gives HTRANS=NONSEQ 2 cycles later (push cycle, then IDLE->ADDR).
  - A zero-wait-state write occupies 2 bus cycles; minimum word period is 3 cycles.
  - Words arrive at least 32 SPI clocks apart, so 2 entries never overflow in legal use.
- Counter width is clog2(DATA_WORD_CNT+1)+1 bits; it saturates and never wraps.
- HRESET mid-transfer: all state returns to reset values in the next cycle, including dropping HTRANS to IDLE. This is allowed because the system asserts the slave resets together.

Decomposition:
- Shared package corebootstrap_pkg:
  - writer state encoding.
  - HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE constants.
- One sub-module: corebootstrap_wfifo, the 2-entry 32-bit FIFO with push/pop/full/empty outputs. The FSM and AHB drive stay in the top level.

Test Plan:
- DATA_WORD_CNT=4, words 11111111..44444444 every 200 cycles, HREADY=1 -> writes at 80000000/04/08/0C with matching HWDATA; wr_all_done=1 and CPU_RESETN=1 after the 4th data phase plus rd_all_done.
- HREADY held low 5 cycles in both the address and data phase of word 2 -> HADDR and HWDATA stable throughout; still exactly 4 writes.
- HRESP=1 on word 3 -> WR_ERR=1, CPU_RESETN stays 0, no 4th transfer ever issued.
- Three rd_data_avail strobes on consecutive cycles with HREADY=0 -> third word dropped, OVFL_ERR=1.
- CKSUM_EN=1: cksum_done with CKSUM_ERR=0 -> release. Rerun with CKSUM_ERR=1 -> WR_ERR=1, CPU_RESETN=0. Rerun with rd_all_done after 3 words -> WR_ERR=1.
- SW_DEBUG_MODE=1 at reset release -> CPU_RESETN=1 within 2 cycles, HTRANS never NONSEQ; HRESET mid-transfer -> HTRANS=00 the next cycle and all outputs at reset values.

Source files
------------

// File: rtl/corebootstrap_pkg.sv
// Shared definitions for the bootstrap AHB writer: FSM state encoding and the
// fixed AHB-Lite control encodings the writer drives.
package corebootstrap_pkg;

   typedef enum logic [2:0] {
      WR_IDLE    = 3'd0,
      WR_ADDR    = 3'd1,
      WR_DATA    = 3'd2,
      WR_CHECK   = 3'd3,
      WR_RELEASE = 3'd4,
      WR_ERROR   = 3'd5
   } wr_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/corebootstrap_ahb_writer_if.sv
// AHB-Lite write-only bus between the bootstrap writer (master) and processor memory.
interface corebootstrap_ahb_if;

   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
      input  HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
      output HREADY, HRESP
   );

endinterface

// File: rtl/corebootstrap_wfifo.sv
// Two-entry 32-bit word buffer between the SPI reader strobe and the AHB writer.
// A push while full or a pop while empty is ignored; the caller flags overflow.
module corebootstrap_wfifo (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        push,
   input  logic [31:0] push_data,
   input  logic        pop,
   output logic [31:0] pop_data,
   output logic        full,
   output logic        empty
);

   logic [31:0] mem_q [2];
   logic [31:0] mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        do_push, do_pop;

   assign full     = (count_q == 2'd2);
   assign empty    = (count_q == 2'd0);
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/corebootstrap_ahb_writer.sv
// Copies bootcode words from the SPI reader into processor memory as single AHB
// writes, then releases the processor reset once the image is complete and valid.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WR_IDLE    | waiting for a buffered word, end of image, or debug bypass
// WR_ADDR    | address phase: NONSEQ on the bus, pop head when accepted
// WR_DATA    | data phase: HWDATA held until HREADY or an error response
// WR_CHECK   | all words in: verify count (and checksum when enabled)
// WR_RELEASE | processor out of reset; terminal
// WR_ERROR   | copy failed, processor held in reset; terminal
module corebootstrap_ahb_writer
   import corebootstrap_pkg::*;
#(
   parameter logic [31:0] DEST_ADDR     = 32'h8000_0000,
   parameter int          DATA_WORD_CNT = 100,
   parameter bit          CKSUM_EN      = 1'b0
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [31:0]          rd_data,
   input  logic                 rd_data_avail,
   input  logic                 rd_all_done,
   input  logic                 cksum_done,
   input  logic                 CKSUM_ERR,
   input  logic                 SW_DEBUG_MODE,
   corebootstrap_ahb_if.master  ahb,
   output logic                 CPU_RESETN,
   output logic                 wr_all_done,
   output logic                 WR_ERR,
   output logic                 OVFL_ERR
);

   localparam int                CNT_W      = $clog2(DATA_WORD_CNT + 1) + 1;
   localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DATA_WORD_CNT);

   wr_state_e        state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      hwdata_q, hwdata_d;
   logic [1:0]       htrans_q, htrans_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_seen_q, done_seen_d;
   logic             cpu_resetn_q, cpu_resetn_d;
   logic             wr_all_done_q, wr_all_done_d;
   logic             wr_err_q, wr_err_d;
   logic             ovfl_err_q, ovfl_err_d;

   logic             accepting;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [31:0]      fifo_rdata;

   corebootstrap_wfifo u_wfifo (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .push      (fifo_push),
      .push_data (rd_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      hwdata_d    = hwdata_q;
      count_d     = count_q;
      fifo_pop    = 1'b0;
      done_seen_d = done_seen_q | rd_all_done;

      // Once terminal, late words are discarded rather than counted as overflow.
      accepting   = (state_q != WR_RELEASE) && (state_q != WR_ERROR);
      fifo_push   = rd_data_avail && accepting && !fifo_full;
      ovfl_err_d  = ovfl_err_q | (rd_data_avail && accepting && fifo_full);

      case (state_q)
         WR_IDLE: begin
            if (SW_DEBUG_MODE)                  state_d = WR_RELEASE;
            else if (!fifo_empty)               state_d = WR_ADDR;
            else if (done_seen_q)               state_d = WR_CHECK;
         end
         WR_ADDR: begin
            if (ahb.HREADY) begin
               fifo_pop = 1'b1;
               hwdata_d = fifo_rdata;
               state_d  = WR_DATA;
            end
         end
         WR_DATA: begin
            if (ahb.HRESP) begin
               state_d = WR_ERROR;
            end else if (ahb.HREADY) begin
               addr_d  = addr_q + 32'd4;
               count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
               state_d = WR_IDLE;
            end
         end
         WR_CHECK: begin
            if (count_q != CNT_TARGET)          state_d = WR_ERROR;
            else if (!CKSUM_EN)                 state_d = WR_RELEASE;
            else if (cksum_done)                state_d = CKSUM_ERR ? WR_ERROR : WR_RELEASE;
         end
         WR_RELEASE: state_d = WR_RELEASE;
         WR_ERROR:   state_d = WR_ERROR;
         default:    state_d = WR_ERROR;
      endcase

      htrans_d      = (state_d == WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      cpu_resetn_d  = (state_d == WR_RELEASE);
      wr_all_done_d = (state_d == WR_RELEASE);
      wr_err_d      = (state_d == WR_ERROR);
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q       <= WR_IDLE;
         addr_q        <= DEST_ADDR;
         hwdata_q      <= 32'd0;
         htrans_q      <= HTRANS_IDLE;
         count_q       <= '0;
         done_seen_q   <= 1'b0;
         cpu_resetn_q  <= 1'b0;
         wr_all_done_q <= 1'b0;
         wr_err_q      <= 1'b0;
         ovfl_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         hwdata_q      <= hwdata_d;
         htrans_q      <= htrans_d;
         count_q       <= count_d;
         done_seen_q   <= done_seen_d;
         cpu_resetn_q  <= cpu_resetn_d;
         wr_all_done_q <= wr_all_done_d;
         wr_err_q      <= wr_err_d;
         ovfl_err_q    <= ovfl_err_d;
      end
   end

   assign ahb.HADDR   = addr_q;
   assign ahb.HTRANS  = htrans_q;
   assign ahb.HWRITE  = 1'b1;
   assign ahb.HSIZE   = HSIZE_WORD;
   assign ahb.HBURST  = HBURST_SINGLE;
   assign ahb.HWDATA  = hwdata_q;
   assign CPU_RESETN  = cpu_resetn_q;
   assign wr_all_done = wr_all_done_q;
   assign WR_ERR      = wr_err_q;
   assign OVFL_ERR    = ovfl_err_q;

endmodule
